// File: rtl/i2s_input_switcher.sv
// N-way I2S source selector: a debounced push button cycles through the sources,
// switching only on an LE frame boundary with DATA muted across the changeover.
`timescale 1ns/1ps
module i2s_input_switcher #(
    parameter int unsigned NUM_INPUTS      = 4,
    parameter int unsigned SEL_W           = $clog2(NUM_INPUTS),
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned MUTE_FRAMES     = 2,
    parameter int unsigned TIMEOUT_CYCLES  = 5000000,
    parameter int unsigned LOCKOUT_CYCLES  = 50000000
) (
    input  logic                  in_clk,
    input  logic                  in_rst_n,
    input  logic [NUM_INPUTS-1:0] in_bck,
    input  logic [NUM_INPUTS-1:0] in_le,
    input  logic [NUM_INPUTS-1:0] in_data,
    input  logic                  in_button,
    output logic                  out_bck,
    output logic                  out_le,
    output logic                  out_data,
    output logic [SEL_W-1:0]      out_selected,
    output logic                  out_mute,
    output logic                  out_busy
);
    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int unsigned FR_W = $clog2(MUTE_FRAMES) + 1;
    localparam int unsigned LK_W = $clog2(LOCKOUT_CYCLES) + 1;

    typedef enum logic [1:0] {IDLE, MUTE_OLD, MUTE_NEW, LOCKOUT} state_t;

    logic                  btn_s1, btn_s2, btn_db, press;
    logic [DB_W-1:0]       db_cnt;
    logic [NUM_INPUTS-1:0] le_s1, le_s2, le_d, le_rise;
    state_t                state;
    logic [SEL_W-1:0]      sel;
    logic [TO_W-1:0]       to_cnt;
    logic [FR_W-1:0]       fr_cnt;
    logic [LK_W-1:0]       lk_cnt;
    logic                  timeout, sel_rise, last_frame;

    // Button: synchronise, accept a level only after it has been stable long enough
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
            btn_db <= 1'b0;
            press  <= 1'b0;
            db_cnt <= '0;
        end else begin
            btn_s1 <= in_button;
            btn_s2 <= btn_s1;
            press  <= 1'b0;
            if (btn_s2 == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                db_cnt <= '0;
                btn_db <= btn_s2;
                press  <= btn_s2;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    // Every source keeps its own LE history, so changing sel cannot create an edge
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            le_s1   <= '0;
            le_s2   <= '0;
            le_d    <= '0;
            le_rise <= '0;
        end else begin
            le_s1   <= in_le;
            le_s2   <= le_s1;
            le_d    <= le_s2;
            le_rise <= le_s2 & ~le_d;
        end
    end

    assign timeout    = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign sel_rise   = le_rise[sel];
    assign last_frame = (fr_cnt == FR_W'(MUTE_FRAMES - 1));

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state    <= IDLE;
            sel      <= '0;
            out_mute <= 1'b0;
            out_busy <= 1'b0;
            to_cnt   <= '0;
            fr_cnt   <= '0;
            lk_cnt   <= '0;
        end else begin
            // Saturating wait counter; each mute state clears it on entry
            if (!timeout) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
            case (state)
                IDLE: begin
                    if (press) begin
                        state    <= MUTE_OLD;
                        out_mute <= 1'b1;
                        out_busy <= 1'b1;
                        to_cnt   <= '0;
                    end
                end
                MUTE_OLD: begin
                    if (sel_rise || timeout) begin
                        sel    <= (sel == SEL_W'(NUM_INPUTS - 1)) ? '0 : sel + SEL_W'(1);
                        state  <= MUTE_NEW;
                        fr_cnt <= '0;
                        to_cnt <= '0;
                    end
                end
                MUTE_NEW: begin
                    if ((sel_rise && last_frame) || timeout) begin
                        out_mute <= 1'b0;
                        state    <= LOCKOUT;
                        lk_cnt   <= '0;
                    end else if (sel_rise) begin
                        fr_cnt <= fr_cnt + FR_W'(1);
                    end
                end
                LOCKOUT: begin
                    if (lk_cnt == LK_W'(LOCKOUT_CYCLES - 1)) begin
                        state    <= IDLE;
                        out_busy <= 1'b0;
                    end else begin
                        lk_cnt <= lk_cnt + LK_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign out_selected = sel;
    assign out_bck      = in_bck[sel];
    assign out_le       = in_le[sel];
    assign out_data     = out_mute ? 1'b0 : in_data[sel];

endmodule

// File: tb/tb_i2s_input_switcher.sv
// Bench for i2s_input_switcher: random I2S-like sources, a timestamp-based
// reference model compared every cycle, plus literal latency/sequence checks.
`timescale 1ns/1ps
module tb_i2s_input_switcher;
    localparam int unsigned N    = 3;
    localparam int unsigned SW   = $clog2(N);
    localparam int unsigned DB   = 4;
    localparam int unsigned MF   = 2;
    localparam int unsigned TO   = 200;
    localparam int unsigned LK   = 100;
    localparam int unsigned PER  = 64;
    localparam int          MAXC = 16384;

    localparam int M_IDLE = 0, M_OLD = 1, M_NEW = 2, M_LOCK = 3;

    logic          in_clk, in_rst_n, in_button;
    logic [N-1:0]  in_bck, in_le, in_data;
    logic          out_bck, out_le, out_data, out_mute, out_busy;
    logic [SW-1:0] out_selected;

    int errors = 0;
    int checks = 0;

    i2s_input_switcher #(
        .NUM_INPUTS(N), .DEBOUNCE_CYCLES(DB), .MUTE_FRAMES(MF),
        .TIMEOUT_CYCLES(TO), .LOCKOUT_CYCLES(LK)
    ) dut (
        .in_clk(in_clk), .in_rst_n(in_rst_n),
        .in_bck(in_bck), .in_le(in_le), .in_data(in_data),
        .in_button(in_button),
        .out_bck(out_bck), .out_le(out_le), .out_data(out_data),
        .out_selected(out_selected), .out_mute(out_mute), .out_busy(out_busy)
    );

    initial begin
        in_clk = 1'b0;
        forever #5 in_clk = ~in_clk;
    end

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Sources: LE square wave of period PER with a random phase, toggling BCK, random DATA
    int unsigned  ph [N];
    int unsigned  cyc;
    logic [N-1:0] le_hold;
    initial begin
        for (int i = 0; i < N; i++) ph[i] = $urandom_range(0, PER - 1);
        cyc = 0;
        in_bck = '0;
        in_le = '0;
        in_data = '0;
        forever begin
            @(posedge in_clk);
            #1;
            cyc++;
            for (int i = 0; i < N; i++) begin
                in_bck[i] = 1'((cyc + 32'(i)) % 2);
                if (!le_hold[i]) in_le[i] = ((cyc + ph[i]) % PER) < (PER / 2);
                in_data[i] = 1'($urandom);
            end
        end
    end

    // Reference model: pin histories indexed by clock edge since reset release
    bit           btn_h [MAXC];
    logic [N-1:0] le_h  [MAXC];
    int           n, m_mode, m_t, m_frames;
    int unsigned  m_sel;
    bit           m_db, m_pend, m_mute, m_busy, press_seen, win;
    logic [N-1:0] rise;

    function automatic bit btn_at(input int m);
        return (m >= 1 && m < MAXC) ? btn_h[m] : 1'b0;
    endfunction

    function automatic logic [N-1:0] le_at(input int m);
        return (m >= 1 && m < MAXC) ? le_h[m] : '0;
    endfunction

    always @(posedge in_clk) begin
        if (!in_rst_n) begin
            n = 0; m_mode = M_IDLE; m_t = 0; m_frames = 0; m_sel = 0;
            m_db = 1'b0; m_pend = 1'b0; m_mute = 1'b0; m_busy = 1'b0;
        end else begin
            n++;
            if (n < MAXC) begin
                btn_h[n] = in_button;
                le_h[n]  = in_le;
            end
            // A pin level reaches the core two edges late; an LE rise is acted on three edges late
            press_seen = m_pend;
            rise = le_at(n - 3) & ~le_at(n - 4);
            win = 1'b1;
            for (int k = 0; k < DB; k++) if (btn_at(n - 2 - k) == m_db) win = 1'b0;
            m_pend = 1'b0;
            if (win) begin
                m_db   = !m_db;
                m_pend = m_db;
            end
            case (m_mode)
                M_IDLE: if (press_seen) begin
                    m_mode = M_OLD; m_t = n; m_mute = 1'b1; m_busy = 1'b1;
                end
                M_OLD: if (rise[m_sel] || (n - m_t == TO)) begin
                    m_sel = (m_sel + 1) % N; m_mode = M_NEW; m_t = n; m_frames = 0;
                end
                M_NEW: begin
                    if (rise[m_sel]) m_frames++;
                    if (m_frames == MF || (n - m_t == TO)) begin
                        m_mute = 1'b0; m_mode = M_LOCK; m_t = n;
                    end
                end
                default: if (n - m_t == LK) begin
                    m_mode = M_IDLE; m_busy = 1'b0;
                end
            endcase
        end
    end

    // Compare every cycle on the falling edge
    always @(negedge in_clk) begin
        if (!in_rst_n) begin
            check("rst_sel", out_selected, 0);
            check("rst_mute", out_mute, 0);
            check("rst_busy", out_busy, 0);
        end else begin
            check("sel", out_selected, m_sel);
            check("mute", out_mute, m_mute);
            check("busy", out_busy, m_busy);
            check("bck", out_bck, in_bck[m_sel]);
            check("le", out_le, in_le[m_sel]);
            check("data", out_data, m_mute ? 1'b0 : in_data[m_sel]);
        end
    end

    task automatic tick(input int k);
        repeat (k) @(posedge in_clk);
        #1;
    endtask

    // Six-cycle press; returns once mute is seen (2 sync + 4 stable + 1 press flop = 7 edges)
    task automatic press_wait_mute(input string name);
        int c;
        in_button = 1'b1;
        c = 0;
        while (!out_mute && c < 12) begin
            tick(1);
            c++;
            if (c == 6) in_button = 1'b0;
        end
        in_button = 1'b0;
        check(name, c, 7);
    endtask

    task automatic do_switch(input int unsigned exp_sel, input bit poke);
        int c;
        press_wait_mute("mute_latency");
        c = 0;
        while (out_mute && c < 1000) begin tick(1); c++; end
        check("unmute", out_mute, 0);
        check("sel_after_switch", out_selected, exp_sel);
        c = 0;
        while (out_busy && c < 500) begin
            tick(1);
            c++;
            if (poke && c == 1) in_button = 1'b1;
        end
        check("lockout_len", c, LK);
        if (poke) begin
            tick(50);
            in_button = 1'b0;
        end
        tick(40);
        check("idle_after", out_busy, 0);
        check("sel_held", out_selected, exp_sel);
    endtask

    int c;
    initial begin
        in_rst_n = 1'b0;
        in_button = 1'b0;
        le_hold = '0;
        tick(4);
        in_rst_n = 1'b1;
        tick(20);
        check("init_sel", out_selected, 0);
        check("init_mute", out_mute, 0);
        check("init_busy", out_busy, 0);

        // Too-short press must not register
        in_button = 1'b1;
        tick(3);
        in_button = 1'b0;
        c = 0;
        repeat (20) begin
            @(negedge in_clk);
            if (out_busy) c++;
        end
        tick(1);
        check("short_press_busy", c, 0);

        do_switch(1, 1'b0);
        do_switch(2, 1'b1);
        do_switch(0, 1'b0);

        // Source 1 LE frozen: switch from 0 still happens, then the new-source wait times out
        le_hold[1] = 1'b1;
        tick(10);
        press_wait_mute("to_mute_latency");
        c = 0;
        while (out_selected == 0 && c < 500) begin tick(1); c++; end
        check("to_sel", out_selected, 1);
        check("to_still_muted", out_mute, 1);
        c = 0;
        while (out_mute && c < 1000) begin tick(1); c++; end
        check("new_timeout_len", c, TO);
        c = 0;
        while (out_busy && c < 500) begin tick(1); c++; end
        check("to_lockout_len", c, LK);
        le_hold[1] = 1'b0;
        tick(20);

        // Reset in the middle of MUTE_NEW
        press_wait_mute("rst_mute_latency");
        c = 0;
        while (out_selected == 1 && c < 500) begin tick(1); c++; end
        check("pre_rst_sel", out_selected, 2);
        tick(3);
        check("pre_rst_mute", out_mute, 1);
        in_rst_n = 1'b0;
        #1;
        check("async_rst_sel", out_selected, 0);
        check("async_rst_mute", out_mute, 0);
        check("async_rst_busy", out_busy, 0);
        tick(3);
        in_rst_n = 1'b1;
        tick(10);
        do_switch(1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
